// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target endpoint: FSM states, SPI mode encodings
// and the edge-selection helper used by the top.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACTIVE = 2'd2
  } spi_state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int BITS_PER_BYTE = 8;

  function automatic logic edge_sel(input logic sel, input logic when_set, input logic when_clr);
    return sel ? when_set : when_clr;
  endfunction

endpackage

// File: rtl/spi_target_if_if.sv
// Pin-level SPI bus between an external master and the target endpoint.
interface spi_target_if_if;
  logic cs;
  logic sclk;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output cs, output sclk, output mosi, input miso, input miso_oe);
  modport slave  (input cs, input sclk, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_in_sync.sv
// Multi-stage synchroniser for one asynchronous SPI pin, with a history flop
// providing single-cycle rise/fall strobes in the sys_clk domain.
module spi_in_sync
  import spi_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/spi_target_if.sv
// SPI target endpoint: oversamples cs/sclk/mosi on sys_clk and runs full-duplex
// 8-bit MSB-first frames, back-to-back within one cs-low window.
//
// state     | meaning
// ST_IDLE   | cs high, miso tri-stated, waiting for cs fall
// ST_LOAD   | one cycle: capture tx_data, pulse tx_req, enable miso
// ST_ACTIVE | shifting bits on synced sclk edges until cs rises
module spi_target_if
  import spi_pkg::*;
#(
  parameter bit CPOL        = 1'b1,
  parameter bit CPHA        = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  spi_target_if_if.slave bus,
  input  logic [7:0]  tx_data,
  output logic        tx_req,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        frame_err
);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (bus.cs),
    .dout      (cs_s),
    .rise      (cs_rise),
    .fall      (cs_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (bus.sclk),
    .dout      (sclk_s),
    .rise      (sclk_rise),
    .fall      (sclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (bus.mosi),
    .dout      (mosi_s),
    .rise      (mosi_rise),
    .fall      (mosi_fall)
  );

  assign unused_sync = &{1'b0, sclk_s, mosi_rise, mosi_fall};

  logic sclk_lead, sclk_trail, sample_edge, shift_edge;

  assign sclk_lead   = edge_sel(CPOL, sclk_fall, sclk_rise);
  assign sclk_trail  = edge_sel(CPOL, sclk_rise, sclk_fall);
  assign sample_edge = edge_sel(CPHA, sclk_trail, sclk_lead);
  assign shift_edge  = edge_sel(CPHA, sclk_lead, sclk_trail);

  spi_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic       oe_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      tx_shift  <= 8'h00;
      rx_shift  <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      oe_q      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
      if (cs_rise) begin
        // cs rise overrides any coincident sclk edge; a partial byte is dropped
        state   <= ST_IDLE;
        oe_q    <= 1'b0;
        bit_cnt <= 3'd0;
        if (bit_cnt != 3'd0) frame_err <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            oe_q    <= 1'b0;
            bit_cnt <= 3'd0;
            if (cs_fall) begin
              state     <= ST_LOAD;
              frame_err <= 1'b0;
            end
          end
          ST_LOAD: begin
            tx_shift <= tx_data;
            tx_req   <= 1'b1;
            oe_q     <= 1'b1;
            rx_shift <= 8'h00;
            state    <= ST_ACTIVE;
          end
          ST_ACTIVE: begin
            if (sample_edge) begin
              rx_shift <= {rx_shift[6:0], mosi_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= {rx_shift[6:0], mosi_s};
                rx_valid <= 1'b1;
                tx_shift <= tx_data;
                tx_req   <= 1'b1;
              end
            end
            // with bit_cnt==0 the MSB of a freshly loaded byte is already on miso
            if (shift_edge && bit_cnt != 3'd0) begin
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.miso    = oe_q & tx_shift[7];
  assign bus.miso_oe = oe_q;
  assign busy        = ~cs_s;

endmodule

// File: tb/tb_spi_target_if.sv
// Bench for spi_target_if: one instance per SPI mode, a pin-level master task,
// and a scoreboard that checks rx bytes on rx_valid and miso bytes at the master.
module tb_spi_target_if;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       cs_d   [4];
  logic       sclk_d [4];
  logic       mosi_d [4];
  logic       miso_w [4];
  logic       oe_w   [4];
  logic [7:0] tx_data_r [4];
  logic       tx_req_w  [4];
  logic [7:0] rx_data_w [4];
  logic       rx_valid_w[4];
  logic       busy_w    [4];
  logic       ferr_w    [4];

  logic [7:0] mout [$];
  logic [7:0] txplan   [4][$];
  logic [7:0] exp_rx   [4][$];
  logic [7:0] exp_miso [4][$];
  int         req_cnt  [4];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_target_if_if bus ();
    assign bus.cs     = cs_d[g];
    assign bus.sclk   = sclk_d[g];
    assign bus.mosi   = mosi_d[g];
    assign miso_w[g]  = bus.miso;
    assign oe_w[g]    = bus.miso_oe;

    spi_target_if #(
      .CPOL        (g >= 2),
      .CPHA        ((g % 2) == 1),
      .SYNC_STAGES ((g == 0) ? 3 : 2)
    ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus.slave),
      .tx_data   (tx_data_r[g]),
      .tx_req    (tx_req_w[g]),
      .rx_data   (rx_data_w[g]),
      .rx_valid  (rx_valid_w[g]),
      .busy      (busy_w[g]),
      .frame_err (ferr_w[g])
    );

    always @(negedge sys_clk) begin
      if (tx_req_w[g]) begin
        req_cnt[g] <= req_cnt[g] + 1;
        exp_miso[g].push_back(tx_data_r[g]);
        if (txplan[g].size() > 0) tx_data_r[g] <= txplan[g].pop_front();
      end
      if (rx_valid_w[g]) begin
        if (exp_rx[g].size() == 0)
          check($sformatf("rx_valid_spurious_d%0d", g), rx_valid_w[g], 1'b0);
        else
          check($sformatf("rx_data_d%0d", g), rx_data_w[g], exp_rx[g].pop_front());
      end
    end
  end

  // Master: sends nbits from mout MSB first; full bytes are expected back on rx
  // and the miso byte must equal what tx_data held when the target loaded it.
  task automatic frame(input int d, input int hp, input int nbits, input bit raise);
    logic cpol, cpha;
    logic [7:0] ob, ib;
    int base, nb;
    cpol = (d >= 2);
    cpha = ((d % 2) == 1);
    base = req_cnt[d];
    cs_d[d] = 1'b0;
    repeat (8) @(negedge sys_clk);
    check($sformatf("tx_req_at_load_d%0d", d), req_cnt[d] - base, 1);
    check($sformatf("busy_d%0d", d), busy_w[d], 1'b1);
    check($sformatf("miso_oe_d%0d", d), oe_w[d], 1'b1);
    check($sformatf("frame_err_clear_d%0d", d), ferr_w[d], 1'b0);
    for (int b = 0; b * 8 < nbits; b++) begin
      ob = mout.pop_front();
      ib = 8'h00;
      nb = (nbits - b * 8 >= 8) ? 8 : nbits - b * 8;
      if (nb == 8) exp_rx[d].push_back(ob);
      for (int i = 0; i < nb; i++) begin
        if (!cpha) begin
          mosi_d[d] = ob[7-i];
          repeat (hp) @(negedge sys_clk);
          ib = {ib[6:0], miso_w[d]};
          sclk_d[d] = ~cpol;
          repeat (hp) @(negedge sys_clk);
          sclk_d[d] = cpol;
        end else begin
          sclk_d[d] = ~cpol;
          mosi_d[d] = ob[7-i];
          repeat (hp) @(negedge sys_clk);
          sclk_d[d] = cpol;
          ib = {ib[6:0], miso_w[d]};
          repeat (hp) @(negedge sys_clk);
        end
      end
      if (nb == 8) begin
        if (exp_miso[d].size() == 0)
          check($sformatf("miso_pending_d%0d", d), exp_miso[d].size(), 1);
        else
          check($sformatf("miso_byte_d%0d", d), ib, exp_miso[d].pop_front());
      end
    end
    repeat (hp + 4) @(negedge sys_clk);
    if (raise) begin
      cs_d[d] = 1'b1;
      repeat (10) @(negedge sys_clk);
      exp_miso[d].delete();
      txplan[d].delete();
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int total, n, base;
    for (int d = 0; d < 4; d++) begin
      cs_d[d] = 1'b1;
      sclk_d[d] = (d >= 2);
      mosi_d[d] = 1'b0;
      tx_data_r[d] = 8'h00;
      req_cnt[d] = 0;
    end
    repeat (3) @(negedge sys_clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_miso_oe_d%0d", d), oe_w[d], 1'b0);
      check($sformatf("rst_miso_d%0d", d), miso_w[d], 1'b0);
      check($sformatf("rst_tx_req_d%0d", d), tx_req_w[d], 1'b0);
      check($sformatf("rst_rx_data_d%0d", d), rx_data_w[d], 8'h00);
      check($sformatf("rst_rx_valid_d%0d", d), rx_valid_w[d], 1'b0);
      check($sformatf("rst_busy_d%0d", d), busy_w[d], 1'b0);
      check($sformatf("rst_frame_err_d%0d", d), ferr_w[d], 1'b0);
    end
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // mode 3 single byte
    tx_data_r[3] = 8'hA5;
    mout.push_back(8'h3C);
    frame(3, 10, 8, 1'b1);
    check("m3_rx_data", rx_data_w[3], 8'h3C);

    // mode 0 three-byte burst with tx_data refreshed after each tx_req
    tx_data_r[0] = 8'hC1;
    txplan[0].push_back(8'hC2);
    txplan[0].push_back(8'hC3);
    mout.push_back(8'h11); mout.push_back(8'h22); mout.push_back(8'h33);
    frame(0, 10, 24, 1'b1);
    check("m0_frame_err", ferr_w[0], 1'b0);
    check("m0_rx_last", rx_data_w[0], 8'h33);

    // partial byte: 5 bits then cs rise
    mout.push_back(8'hF0);
    frame(3, 10, 5, 1'b1);
    check("partial_frame_err", ferr_w[3], 1'b1);
    check("partial_rx_hold", rx_data_w[3], 8'h3C);
    tx_data_r[3] = 8'h69;
    mout.push_back(8'h96);
    frame(3, 10, 8, 1'b1);
    check("after_partial_ferr", ferr_w[3], 1'b0);
    check("after_partial_rx", rx_data_w[3], 8'h96);

    // sclk activity with cs high
    for (int d = 0; d < 4; d++) req_cnt[d] = req_cnt[d];
    base = req_cnt[0] + req_cnt[1] + req_cnt[2] + req_cnt[3];
    for (int e = 0; e < 16; e++) begin
      for (int d = 0; d < 4; d++) sclk_d[d] = ~sclk_d[d];
      repeat (10) @(negedge sys_clk);
      for (int d = 0; d < 4; d++) begin
        check($sformatf("idle_sclk_oe_d%0d", d), oe_w[d], 1'b0);
        check($sformatf("idle_sclk_miso_d%0d", d), miso_w[d], 1'b0);
      end
    end
    check("idle_sclk_tx_req", req_cnt[0] + req_cnt[1] + req_cnt[2] + req_cnt[3] - base, 0);

    // reset mid-byte on mode 2
    tx_data_r[2] = 8'h77;
    mout.push_back(8'hE1);
    frame(2, 10, 4, 1'b0);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("midrst_oe", oe_w[2], 1'b0);
    check("midrst_miso", miso_w[2], 1'b0);
    check("midrst_busy", busy_w[2], 1'b0);
    check("midrst_rx_data", rx_data_w[2], 8'h00);
    check("midrst_frame_err", ferr_w[2], 1'b0);
    check("midrst_tx_req", tx_req_w[2], 1'b0);
    cs_d[2] = 1'b1;
    sclk_d[2] = 1'b1;
    exp_miso[2].delete();
    txplan[2].delete();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    check("postrst_busy", busy_w[2], 1'b0);
    check("postrst_frame_err", ferr_w[2], 1'b0);
    tx_data_r[2] = 8'h3B;
    mout.push_back(8'h5A);
    frame(2, 10, 8, 1'b1);
    check("postrst_rx", rx_data_w[2], 8'h5A);

    // modes 1 and 2 at sclk = sys_clk/8, 100 random bytes each
    for (int d = 1; d <= 2; d++) begin
      total = 0;
      while (total < 100) begin
        n = $urandom_range(1, 8);
        if (n > 100 - total) n = 100 - total;
        tx_data_r[d] = 8'($urandom);
        for (int k = 0; k < n; k++) begin
          txplan[d].push_back(8'($urandom));
          mout.push_back(8'($urandom));
        end
        frame(d, 4, n * 8, 1'b1);
        total += n;
      end
      check($sformatf("rand_frame_err_d%0d", d), ferr_w[d], 1'b0);
    end

    repeat (10) @(negedge sys_clk);
    for (int d = 0; d < 4; d++)
      check($sformatf("rx_outstanding_d%0d", d), exp_rx[d].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
